// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end for the shared 3-bit Alu.
// Two requesters compete for the Alu; the winner's operands are latched,
// held on the Alu inputs for HOLD_CYCLES cycles, and the captured result
// and flags are returned to the winner over a valid/ready response channel.
module alu_arbiter #(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter logic        RR_INIT     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_a,
  input  logic [2:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_a,
  input  logic [2:0] req1_b,
  input  logic [1:0] req1_op,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [4:0] rsp0_result,
  output logic [2:0] rsp0_flags,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [4:0] rsp1_result,
  output logic [2:0] rsp1_flags,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  output logic [1:0] alu_s,
  input  logic [4:0] alu_r,
  input  logic       alu_sf,
  input  logic       alu_zf,
  input  logic       alu_dzf,
  output logic       busy
);

  // Out-of-range hold values are clamped into the 4-bit counter's range.
  localparam int unsigned HOLD_EFF =
    (HOLD_CYCLES < 32'd1)  ? 32'd1  :
    (HOLD_CYCLES > 32'd15) ? 32'd15 : HOLD_CYCLES;
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_EFF - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            owner_q, owner_d;
  logic [2:0]      a_q, a_d;
  logic [2:0]      b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic [1:0][4:0] rsp_result_q, rsp_result_d;
  logic [1:0][2:0] rsp_flags_q, rsp_flags_d;
  logic            busy_q, busy_d;

  logic            grant_valid_s;
  logic            grant_id_s;
  logic            idle_s;
  logic            accept_s;
  logic            owner_rsp_ready_s;

  // Grant selection: a lone requester wins, contention goes to the pointer.
  always_comb begin
    grant_valid_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id_s = ptr_q;
    end else if (req1_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
    idle_s            = (state_q == IDLE) && rst_n;
    accept_s          = idle_s && grant_valid_s;
    owner_rsp_ready_s = owner_q ? rsp1_ready : rsp0_ready;
  end

  assign req0_ready = accept_s && (grant_id_s == 1'b0);
  assign req1_ready = accept_s && (grant_id_s == 1'b1);

  // Next-state logic: accept in IDLE, count down in ISSUE, handshake in RESP.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          owner_d = grant_id_s;
          ptr_d   = ~grant_id_s;
          a_d     = grant_id_s ? req1_a  : req0_a;
          b_d     = grant_id_s ? req1_b  : req0_b;
          op_d    = grant_id_s ? req1_op : req0_op;
          cnt_d   = HOLD_LOAD;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_valid_d[owner_q]  = 1'b1;
          rsp_result_d[owner_q] = alu_r;
          rsp_flags_d[owner_q]  = {alu_dzf, alu_zf, alu_sf};
          state_d               = RESP;
        end
      end
      RESP: begin
        // Response data is cleared with valid so idle channels read as zero.
        if (owner_rsp_ready_s) begin
          rsp_valid_d  = 2'b00;
          rsp_result_d = '0;
          rsp_flags_d  = '0;
          state_d      = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp_valid_d  = 2'b00;
        rsp_result_d = '0;
        rsp_flags_d  = '0;
        state_d      = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= RR_INIT;
      owner_q      <= 1'b0;
      a_q          <= 3'd0;
      b_q          <= 3'd0;
      op_q         <= 2'd0;
      cnt_q        <= 4'd0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      busy_q       <= busy_d;
    end
  end

  // Alu inputs come only from the latched command, never the live inputs.
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_s       = op_q;
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_result = rsp_result_q[0];
  assign rsp1_result = rsp_result_q[1];
  assign rsp0_flags  = rsp_flags_q[0];
  assign rsp1_flags  = rsp_flags_q[1];
  assign busy        = busy_q;

endmodule
